// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and constants for the APB4 initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W = 12;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    // Transfer phases of the initiator
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // One register command as issued by the agent
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_cmd_t;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_wait_timer
//  Description : Counts ACCESS wait states; flags expiry on the last allowed
//                cycle. TIMEOUT_CYCLES = 0 disables expiry entirely.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
        // Timeout disabled: expiry never fires
        assign expire_o = 1'b0;
    end else begin : g_timeout
        localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
        localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;

        // Next count: clear wins, otherwise count one wait state, saturating at LAST
        always_comb begin
            count_d = count_q;
            if (clear_i) begin
                count_d = '0;
            end else if (enable_i && (count_q != LAST)) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        // Counter register
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        // Expiry means the current ACCESS cycle is the last one allowed
        assign expire_o = (count_q == LAST);
    end

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master
//  Description : APB4 initiator. Turns single agent commands into SETUP/ACCESS
//                transfers and returns read data or an error/timeout response.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master
    import apb_pkg::*;
#(
    parameter int          ADDR_W         = APB_ADDR_W,
    parameter int          DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  prst,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    // response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB side
    output logic [ADDR_W-1:0]     paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    input  logic                  pready,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;

    apb_state_e         state_q,       state_d;
    logic               cmd_ready_q,   cmd_ready_d;
    logic               psel_q,        psel_d;
    logic               penable_q,     penable_d;
    logic               pwrite_q,      pwrite_d;
    logic [ADDR_W-1:0]  paddr_q,       paddr_d;
    logic [DATA_W-1:0]  pwdata_q,      pwdata_d;
    logic [STRB_W-1:0]  pstrb_q,       pstrb_d;
    logic               rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q,   rsp_rdata_d;
    logic               rsp_err_q,     rsp_err_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    logic timer_clear;
    logic timer_en;
    logic timer_expire;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i    (pclk),
        .rst_i    (prst),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expire_o (timer_expire)
    );

    // Next-state and next-output logic; every register holds unless a phase changes it
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        timer_clear   = 1'b0;
        timer_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    // Reads carry no data or strobes on the bus
                    pwdata_d    = cmd_write ? cmd_wdata : '0;
                    pstrb_d     = cmd_write ? cmd_strb  : '0;
                end
            end

            SETUP: begin
                // pready is not looked at here; ACCESS always follows
                state_d     = ACCESS;
                penable_d   = 1'b1;
                timer_clear = 1'b1;
            end

            ACCESS: begin
                if (pready) begin
                    state_d       = RESP;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expire) begin
                    state_d       = RESP;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end

                if (state_d == RESP) begin
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    paddr_d     = '0;
                    pwdata_d    = '0;
                    pstrb_d     = '0;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b0;
                    cmd_ready_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer and pending response
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master
//  Description : Self-checking bench for apb_master: directed scenarios plus
//                randomized transfers checked against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;
    import apb_pkg::*;

    localparam int TO = 16;

    logic                  pclk = 1'b0;
    logic                  prst;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [APB_ADDR_W-1:0] cmd_addr;
    logic [APB_DATA_W-1:0] cmd_wdata;
    logic [APB_STRB_W-1:0] cmd_strb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [APB_DATA_W-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic [APB_ADDR_W-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_STRB_W-1:0] pstrb;
    logic                  pready;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pslverr;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_master #(
        .ADDR_W         (APB_ADDR_W),
        .DATA_W         (APB_DATA_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk        (pclk),
        .prst        (prst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  to;
    } rsp_t;

    // Transaction-level expectation: a slave that answers after 'waits' wait
    // states either finishes within the timeout budget or is aborted.
    function automatic rsp_t model(input apb_cmd_t c, input int waits,
                                   input logic [APB_DATA_W-1:0] rd, input logic e);
        rsp_t r;
        if (TO != 0 && waits >= TO) begin
            r.rdata = '0;
            r.err   = 1'b1;
            r.to    = 1'b1;
        end else begin
            r.rdata = c.write ? '0 : rd;
            r.err   = e;
            r.to    = 1'b0;
        end
        return r;
    endfunction

    function automatic apb_cmd_t rand_cmd();
        apb_cmd_t c;
        c.write = 1'($urandom_range(0, 1));
        c.addr  = APB_ADDR_W'($urandom);
        c.wdata = $urandom;
        c.strb  = APB_STRB_W'($urandom);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input apb_cmd_t c);
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        cmd_strb  = c.strb;
    endtask

    task automatic next_cycle();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    // One full transfer starting from IDLE at a negedge. 'delay' cycles of
    // response backpressure; with 'busy' a second command is offered meanwhile.
    task automatic run_txn(input apb_cmd_t c, input int waits,
                           input logic [APB_DATA_W-1:0] rd, input logic e,
                           input int delay, input logic busy, input apb_cmd_t nxt);
        int   n_acc;
        rsp_t r;
        logic [APB_DATA_W-1:0] exp_wd;
        logic [APB_STRB_W-1:0] exp_st;
        r      = model(c, waits, rd, e);
        n_acc  = (waits >= TO) ? TO : waits + 1;
        exp_wd = c.write ? c.wdata : '0;
        exp_st = c.write ? c.strb  : '0;

        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        drive_cmd(c);
        next_cycle();
        cmd_valid = 1'b0;
        // SETUP cycle; a random pready here must have no effect
        pready  = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
        chk("setup_psel",      64'(psel),      64'd1);
        chk("setup_penable",   64'(penable),   64'd0);
        chk("setup_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("setup_paddr",     64'(paddr),     64'(c.addr));
        chk("setup_pwrite",    64'(pwrite),    64'(c.write));
        chk("setup_pwdata",    64'(pwdata),    64'(exp_wd));
        chk("setup_pstrb",     64'(pstrb),     64'(exp_st));

        for (int k = 0; k < n_acc; k++) begin
            next_cycle();
            chk("acc_psel",      64'(psel),      64'd1);
            chk("acc_penable",   64'(penable),   64'd1);
            chk("acc_paddr",     64'(paddr),     64'(c.addr));
            chk("acc_pwdata",    64'(pwdata),    64'(exp_wd));
            chk("acc_pstrb",     64'(pstrb),     64'(exp_st));
            chk("acc_rsp_valid", 64'(rsp_valid), 64'd0);
            pready  = (k == waits);
            prdata  = (k == waits) ? rd : $urandom;
            pslverr = (k == waits) ? e  : 1'($urandom_range(0, 1));
        end

        next_cycle();
        pready    = 1'b0;
        rsp_ready = (delay == 0);
        if (busy) drive_cmd(nxt);
        chk("resp_valid",   64'(rsp_valid),   64'd1);
        chk("resp_rdata",   64'(rsp_rdata),   64'(r.rdata));
        chk("resp_err",     64'(rsp_err),     64'(r.err));
        chk("resp_timeout", 64'(rsp_timeout), 64'(r.to));
        chk("resp_psel",    64'(psel),        64'd0);
        chk("resp_penable", 64'(penable),     64'd0);
        chk("resp_paddr",   64'(paddr),       64'd0);
        chk("resp_pwdata",  64'(pwdata),      64'd0);
        chk("resp_pstrb",   64'(pstrb),       64'd0);

        for (int d = 0; d < delay; d++) begin
            next_cycle();
            chk("bp_valid",     64'(rsp_valid),   64'd1);
            chk("bp_rdata",     64'(rsp_rdata),   64'(r.rdata));
            chk("bp_err",       64'(rsp_err),     64'(r.err));
            chk("bp_timeout",   64'(rsp_timeout), 64'(r.to));
            chk("bp_cmd_ready", 64'(cmd_ready),   64'd0);
            chk("bp_psel",      64'(psel),        64'd0);
            if (d == delay - 1) rsp_ready = 1'b1;
        end

        next_cycle();
        rsp_ready = 1'b0;
        chk("done_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("done_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("done_psel",      64'(psel),      64'd0);
    endtask

    initial begin
        apb_cmd_t c;
        apb_cmd_t nxt;
        apb_cmd_t pend;
        logic     have_pend;
        int       waits;
        int       delay;
        logic     busy;

        prst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        next_cycle();
        next_cycle();
        chk("rst_cmd_ready", 64'(cmd_ready),   64'd1);
        chk("rst_psel",      64'(psel),        64'd0);
        chk("rst_penable",   64'(penable),     64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid),   64'd0);
        chk("rst_paddr",     64'(paddr),       64'd0);
        chk("rst_pwdata",    64'(pwdata),      64'd0);
        chk("rst_rsp_err",   64'(rsp_err),     64'd0);
        prst = 1'b0;
        next_cycle();

        // Write with zero wait states
        c = '{write: 1'b1, addr: 12'h010, wdata: 32'hA5A5_1234, strb: 4'hF};
        run_txn(c, 0, 32'h0, 1'b0, 0, 1'b0, c);
        // Read with three wait states
        c = '{write: 1'b0, addr: 12'h004, wdata: 32'h1111_2222, strb: 4'hF};
        run_txn(c, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, c);
        // Slave error on the top address
        c = '{write: 1'b0, addr: 12'hFFC, wdata: 32'h0, strb: 4'h0};
        run_txn(c, 0, 32'h1234_5678, 1'b1, 1, 1'b0, c);
        // Timeout, then pready on the last allowed ACCESS cycle
        c = '{write: 1'b0, addr: 12'h020, wdata: 32'h0, strb: 4'h0};
        run_txn(c, TO, 32'hCAFE_F00D, 1'b0, 0, 1'b0, c);
        run_txn(c, TO - 1, 32'hCAFE_F00D, 1'b0, 0, 1'b0, c);
        // Write with zero strobes, held response while a second command waits
        c   = '{write: 1'b1, addr: 12'h031, wdata: 32'h0BAD_F00D, strb: 4'h0};
        nxt = '{write: 1'b0, addr: 12'h044, wdata: 32'h0, strb: 4'h0};
        run_txn(c, 1, 32'h0, 1'b0, 5, 1'b1, nxt);
        chk("busy_handoff_psel", 64'(psel), 64'd0);
        run_txn(nxt, 2, 32'h5555_AAAA, 1'b0, 0, 1'b0, nxt);

        // Reset during a wait state abandons the transfer
        c = '{write: 1'b0, addr: 12'h008, wdata: 32'h0, strb: 4'h0};
        drive_cmd(c);
        next_cycle();
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) next_cycle();
        chk("pre_rst_penable", 64'(penable), 64'd1);
        prst   = 1'b1;
        pready = 1'b1;
        next_cycle();
        prst = 1'b0;
        chk("mid_rst_psel",      64'(psel),      64'd0);
        chk("mid_rst_penable",   64'(penable),   64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("post_rst_psel",      64'(psel),      64'd0);
        end
        pready = 1'b0;

        // Randomized transfers
        have_pend = 1'b0;
        pend      = '0;
        for (int n = 0; n < 30; n++) begin
            c     = have_pend ? pend : rand_cmd();
            nxt   = rand_cmd();
            waits = $urandom_range(0, TO + 3);
            delay = $urandom_range(0, 3);
            busy  = (delay > 0) && ($urandom_range(0, 1) == 1);
            run_txn(c, waits, $urandom, 1'($urandom_range(0, 1)), delay, busy, nxt);
            have_pend = busy;
            pend      = nxt;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
